// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - registered 8-bit ripple-carry adder with carry-in/carry-out
module adder_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;
  logic [7:0] s;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling from LSB to MSB.
  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= 8'h00;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[8];
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// tb/tb_adder_8bit.sv - scoreboard bench for adder_8bit
module tb_adder_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  adder_8bit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .sum (sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] exp;
    int         id;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [8:0] prev;
  bit         have_prev = 1'b0;

  // Drive one vector midway between edges; the result must still show the
  // previous vector's value until the next rising edge.
  task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [8:0] e, input int id);
    exp_t t;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    cin = vc;
    t.exp = e;
    t.id  = id;
    q.push_back(t);
    #1;
    if (have_prev) begin
      checks++;
      if ({cout, sum} !== prev) begin
        failures++;
        $display("FAIL hold id=%0d got={cout,sum}=%h want=%h", id, {cout, sum}, prev);
      end
    end
    prev      = e;
    have_prev = 1'b1;
  endtask

  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        t = q.pop_front();
        checks++;
        if ({cout, sum} !== t.exp) begin
          failures++;
          $display("FAIL result id=%0d got={cout,sum}=%h want=%h", t.id, {cout, sum}, t.exp);
        end
      end
    end
  end

  // rst, a, b, cin, expected {cout,sum} (hand-computed)
  localparam int NV = 16;
  logic       v_rst[NV] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  logic [7:0] v_a[NV]   = '{8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h12, 8'hFF, 8'h80, 8'h01,
                            8'h10, 8'h55, 8'h55, 8'hC8, 8'h7F, 8'h7F, 8'h00, 8'hF0};
  logic [7:0] v_b[NV]   = '{8'hFF, 8'hFF, 8'hFF, 8'h34, 8'h34, 8'h00, 8'h80, 8'h01,
                            8'h20, 8'hAA, 8'hAA, 8'h64, 8'h01, 8'h01, 8'h00, 8'h0F};
  logic       v_cin[NV] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
  logic [8:0] v_exp[NV] = '{9'h000, 9'h000, 9'h1FF, 9'h046, 9'h047, 9'h100, 9'h100, 9'h002,
                            9'h030, 9'h0FF, 9'h100, 9'h12D, 9'h000, 9'h080, 9'h000, 9'h100};

  initial begin : stim
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    rst = 1'b1;
    a   = 8'hFF;
    b   = 8'hFF;
    cin = 1'b1;

    for (int i = 0; i < NV; i++)
      drive(v_rst[i], v_a[i], v_b[i], v_cin[i], v_exp[i], i);

    // Inputs changed again within the same cycle: only the last value counts.
    drive(1'b0, 8'hFF, 8'hFF, 1'b1, 9'h030, 100);
    a   = 8'h10;
    b   = 8'h20;
    cin = 1'b0;

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive(1'b0, ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc}, 1000 + i);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_8bit.md
# adder_8bit

Registered 8-bit binary adder with carry-in and carry-out. Computes `a + b + cin` through an 8-stage ripple-carry chain of full-adder cells and captures `sum` and `cout` on the rising clock edge. It is a leaf arithmetic block for datapaths that need a one-cycle, fully synchronous add.

## Interface

- No parameters; width fixed at 8 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `a`  in  8  addend A, unsigned.
- `b`  in  8  addend B, unsigned.
- `cin`  in  1  carry-in, weight 1.
- `sum`  out  8  registered low 8 bits of `a + b + cin`.
- `cout`  out  1  registered carry-out, bit 8 of `a + b + cin`.

## Operation

- Combinational core: 8 full-adder cells chained LSB to MSB.
  - Cell i: `s[i] = a[i] ^ b[i] ^ c[i]`.
  - Cell i: `c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))`.
  - `c[0] = cin`.
- Result is the 9-bit value `{c[8], s[7:0]}`, which equals `a + b + cin` exactly. Range is 0 to 511.
- Register stage:
  - On each rising edge with `rst` = 1: `sum` <= 8'h00 and `cout` <= 0.
  - On each rising edge with `rst` = 0: `sum` <= `s[7:0]` and `cout` <= `c[8]`.
- Unsigned arithmetic only. No overflow flag and no saturation; wrap-around is carried entirely by `cout`.
- Inputs may change at any time between clock edges. Only the values present at the rising edge matter.
- No enable: the register loads every cycle.

## Timing

- Latency is 1 cycle. Inputs sampled at rising edge N appear on `sum`/`cout` immediately after edge N. They hold until edge N+1.
- Throughput is one add per cycle, with no stall and no handshake.
- Outputs are registered only and must not glitch between edges.
- Power-up value before the first edge is undefined. After any edge with `rst` = 1, `sum` = 8'h00 and `cout` = 0.
- Reset behaviour:
  - Reset has priority over the add on the same edge.
  - Asserting `rst` mid-stream clears the outputs on that edge.
  - Deasserting `rst` makes the next edge load the current sum.
- Combinational path: ripple through 8 cells. It must meet one clock period, which is 10 ns in the standard bench.
- Standard bench checking scheme:
  - Inputs change midway between edges.
  - The bench checks one period later, so one rising edge has occurred.
  - At the check, `sum` must equal `(a + b + cin) & 8'hFF`.

## Test plan

- Reset: `rst` = 1 for 2 edges with `a` = 8'hFF, `b` = 8'hFF, `cin` = 1 -> `sum` = 8'h00, `cout` = 0. Release `rst` -> next edge gives `sum` = 8'hFF, `cout` = 1.
- Basic adds, with `rst` = 0:
  - `a` = 8'h12, `b` = 8'h34, `cin` = 0 -> `sum` = 8'h46, `cout` = 0.
  - `a` = 8'h12, `b` = 8'h34, `cin` = 1 -> `sum` = 8'h47, `cout` = 0.
- Wrap-around and full carry ripple:
  - `a` = 8'hFF, `b` = 8'h00, `cin` = 1 -> `sum` = 8'h00, `cout` = 1.
  - `a` = 8'h80, `b` = 8'h80, `cin` = 0 -> `sum` = 8'h00, `cout` = 1.
- Latency: apply `a` = 8'h01, `b` = 8'h01, `cin` = 0 between edges.
  - Before the next edge, outputs still show the previous result.
  - After the edge, `sum` = 8'h02.
  - Change the inputs to 8'h10 / 8'h20 / 0 mid-cycle -> `sum` = 8'h30 only after the following edge.
- Mid-stream reset: during back-to-back adds, assert `rst` for one edge -> that edge gives `sum` = 8'h00, `cout` = 0. The next edge resumes with the current input sum.
- Random regression:
  - 1,000,000 random (`a`, `b`, `cin`) vectors, one per cycle, each checked one cycle later.
  - Required: zero mismatches of `sum` against `(a + b + cin) & 8'hFF`, and of `cout` against `(a + b + cin) >> 8`.
